// File: rtl/hazard_controller_if.sv
// Hazard controller port bundle: ID-stage operand/dest info and branch resolve in,
// forwarding selects, stall/flush controls and event counters out.
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             branch_taken;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             stall;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, branch_taken,
    input  forward_a, forward_b, stall, flush_if_id, flush_id_ex,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_reg_write, id_mem_read, branch_taken,
    output forward_a, forward_b, stall, flush_if_id, flush_id_ex,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Forwarding selects, load-use stall and branch flush for the 5-stage core; all
// controls combinational from shadowed EX/MEM/WB records (zero latency), no backpressure.
module hazard_controller #(
  parameter int CNT_W = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } ex_rec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } wr_rec_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ex_rec_t          ex_q, ex_d;
  wr_rec_t          mem_q, mem_d;
  wr_rec_t          wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic mem_src;
  logic wb_src;
  logic lu;
  logic stall;
  logic flush_id_ex;

  always_comb begin
    mem_src = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0);
    wb_src  = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);

    lu = hif.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
         ((hif.id_uses_rs1 & (ex_q.rd == hif.id_rs1)) |
          (hif.id_uses_rs2 & (ex_q.rd == hif.id_rs2)));

    // A taken branch squashes the stalled ID instruction, so flush wins.
    stall       = lu & ~hif.branch_taken;
    flush_id_ex = hif.branch_taken | lu;

    hif.forward_a = 2'b00;
    if (ex_q.valid && ex_q.uses_rs1) begin
      if (mem_src && (mem_q.rd == ex_q.rs1)) begin
        hif.forward_a = 2'b10;
      end else if (wb_src && (wb_q.rd == ex_q.rs1)) begin
        hif.forward_a = 2'b01;
      end
    end

    hif.forward_b = 2'b00;
    if (ex_q.valid && ex_q.uses_rs2) begin
      if (mem_src && (mem_q.rd == ex_q.rs2)) begin
        hif.forward_b = 2'b10;
      end else if (wb_src && (wb_q.rd == ex_q.rs2)) begin
        hif.forward_b = 2'b01;
      end
    end

    hif.stall       = stall;
    hif.flush_if_id = hif.branch_taken;
    hif.flush_id_ex = flush_id_ex;
    hif.stall_count = stall_count_q;
    hif.flush_count = flush_count_q;
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};

    ex_d = '0;
    if (hif.id_valid && !flush_id_ex) begin
      ex_d = '{valid:     1'b1,
               rs1:       hif.id_rs1,
               rs2:       hif.id_rs2,
               uses_rs1:  hif.id_uses_rs1,
               uses_rs2:  hif.id_uses_rs2,
               rd:        hif.id_rd,
               reg_write: hif.id_reg_write,
               mem_read:  hif.id_mem_read};
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end

    flush_count_d = flush_count_q;
    if (hif.branch_taken && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized and directed bench for hazard_controller against an instruction-history model;
// a second instance with 4-bit counters exercises saturation.
module tb_hazard_controller;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(32)) hif ();
  hazard_controller_if #(.CNT_W(4))  hif4 ();

  hazard_controller #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .hif(hif.slave));
  hazard_controller #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .hif(hif4.slave));

  int          n_checks = 0;
  int          n_fail   = 0;
  // hist[0] is the instruction now in EX, hist[1] one older, hist[2] two older
  ins_t        hist[3];
  int unsigned m_stalls;
  int unsigned m_flushes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t alu(input int rd, input int rs1, input int rs2);
    ins_t r = '0;
    r.v = 1'b1; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.u1 = 1'b1; r.u2 = 1'b1; r.rw = 1'b1;
    return r;
  endfunction

  function automatic ins_t ld(input int rd, input int rs1);
    ins_t r = '0;
    r.v = 1'b1; r.rd = 5'(rd); r.rs1 = 5'(rs1);
    r.u1 = 1'b1; r.rw = 1'b1; r.mr = 1'b1;
    return r;
  endfunction

  function automatic ins_t nop();
    ins_t r = '0;
    r.v = 1'b1;
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t r;
    r.v   = ($urandom_range(0, 9) != 0);
    r.rs1 = 5'($urandom_range(0, 7));
    r.rs2 = 5'($urandom_range(0, 7));
    r.u1  = 1'($urandom_range(0, 1));
    r.u2  = 1'($urandom_range(0, 1));
    r.rd  = 5'($urandom_range(0, 7));
    r.rw  = 1'($urandom_range(0, 1));
    r.mr  = r.rw & ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  // Select from the nearest older instruction that writes the needed register.
  function automatic logic [1:0] exp_fwd(input logic use_src, input logic [4:0] rs);
    if (!hist[0].v || !use_src) return 2'b00;
    for (int d = 1; d <= 2; d++) begin
      if (hist[d].v && hist[d].rw && hist[d].rd != 5'd0 && hist[d].rd == rs)
        return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic int unsigned sat4(input int unsigned n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic drive(input ins_t i, input logic br);
    hif.id_valid = i.v;  hif.id_rs1 = i.rs1; hif.id_rs2 = i.rs2;
    hif.id_uses_rs1 = i.u1; hif.id_uses_rs2 = i.u2; hif.id_rd = i.rd;
    hif.id_reg_write = i.rw; hif.id_mem_read = i.mr; hif.branch_taken = br;
    hif4.id_valid = i.v;  hif4.id_rs1 = i.rs1; hif4.id_rs2 = i.rs2;
    hif4.id_uses_rs1 = i.u1; hif4.id_uses_rs2 = i.u2; hif4.id_rd = i.rd;
    hif4.id_reg_write = i.rw; hif4.id_mem_read = i.mr; hif4.branch_taken = br;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // One pipeline cycle: present ID/branch, check all outputs, advance the model.
  task automatic step(input ins_t id, input logic br, output logic stl);
    logic lu, es, ef;
    @(negedge clk);
    drive(id, br);
    #1;
    lu = id.v && hist[0].v && hist[0].mr && hist[0].rd != 5'd0 &&
         ((id.u1 && hist[0].rd == id.rs1) || (id.u2 && hist[0].rd == id.rs2));
    es = lu && !br;
    ef = lu || br;
    check("stall_count",  hif.stall_count,  m_stalls);
    check("flush_count",  hif.flush_count,  m_flushes);
    check("stall_count4", 32'(hif4.stall_count), sat4(m_stalls));
    check("flush_count4", 32'(hif4.flush_count), sat4(m_flushes));
    check("forward_a",    32'(hif.forward_a), 32'(exp_fwd(hist[0].u1, hist[0].rs1)));
    check("forward_b",    32'(hif.forward_b), 32'(exp_fwd(hist[0].u2, hist[0].rs2)));
    check("stall",        32'(hif.stall),       32'(es));
    check("flush_if_id",  32'(hif.flush_if_id), 32'(br));
    check("flush_id_ex",  32'(hif.flush_id_ex), 32'(ef));
    check("stall4",       32'(hif4.stall),      32'(es));
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = (ef || !id.v) ? '0 : id;
    if (es) m_stalls++;
    if (br) m_flushes++;
    stl = es;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, 1'b0);
    model_clear();
    #12;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fa"},   32'(hif.forward_a), 0);
    check({tag, "_fb"},   32'(hif.forward_b), 0);
    check({tag, "_st"},   32'(hif.stall), 0);
    check({tag, "_fie"},  32'(hif.flush_id_ex), 0);
    check({tag, "_fii"},  32'(hif.flush_if_id), 0);
    check({tag, "_sc"},   hif.stall_count, 0);
    check({tag, "_fc"},   hif.flush_count, 0);
    check({tag, "_sc4"},  32'(hif4.stall_count), 0);
  endtask

  initial begin
    logic s;
    ins_t cur;
    rst = 1'b0;
    drive('0, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("reset");
    do_reset();

    // Load-use: one stall cycle, then WB forward two cycles on.
    step(ld(9, 1), 1'b0, s);
    check("lu_cnt_before", hif.stall_count, 0);
    step(alu(10, 9, 1), 1'b0, s);
    check("lu_stall", 32'(hif.stall), 1);
    check("lu_flush_id_ex", 32'(hif.flush_id_ex), 1);
    step(alu(10, 9, 1), 1'b0, s);
    check("lu_stall_once", 32'(hif.stall), 0);
    check("lu_cnt_after", hif.stall_count, 1);
    step(nop(), 1'b0, s);
    check("lu_fwd_wb", 32'(hif.forward_a), 32'(2'b01));

    // Same sequence on x0.
    step(ld(0, 1), 1'b0, s);
    step(alu(10, 0, 1), 1'b0, s);
    check("x0_no_stall", 32'(hif.stall), 0);
    step(nop(), 1'b0, s);
    check("x0_fa", 32'(hif.forward_a), 0);
    for (int k = 0; k < 3; k++) step(nop(), 1'b0, s);

    // ALU chain.
    step(alu(5, 1, 2), 1'b0, s);
    step(alu(6, 5, 3), 1'b0, s);
    check("chain_no_stall", 32'(hif.stall), 0);
    step(nop(), 1'b0, s);
    check("chain_fa", 32'(hif.forward_a), 32'(2'b10));
    check("chain_fb", 32'(hif.forward_b), 0);
    for (int k = 0; k < 3; k++) step(nop(), 1'b0, s);

    // One and two instruction gaps.
    step(alu(5, 1, 2), 1'b0, s);
    step(nop(), 1'b0, s);
    step(alu(7, 3, 5), 1'b0, s);
    step(nop(), 1'b0, s);
    check("gap1_fb", 32'(hif.forward_b), 32'(2'b01));
    for (int k = 0; k < 3; k++) step(nop(), 1'b0, s);
    step(alu(5, 1, 2), 1'b0, s);
    step(nop(), 1'b0, s);
    step(nop(), 1'b0, s);
    step(alu(7, 3, 5), 1'b0, s);
    step(nop(), 1'b0, s);
    check("gap2_fb", 32'(hif.forward_b), 0);
    for (int k = 0; k < 3; k++) step(nop(), 1'b0, s);

    // Double hazard: MEM beats WB.
    step(alu(5, 1, 2), 1'b0, s);
    step(alu(5, 3, 4), 1'b0, s);
    step(alu(8, 5, 5), 1'b0, s);
    step(nop(), 1'b0, s);
    check("dbl_fa", 32'(hif.forward_a), 32'(2'b10));
    check("dbl_fb", 32'(hif.forward_b), 32'(2'b10));

    // Branch colliding with load-use.
    step(ld(9, 1), 1'b0, s);
    step(alu(10, 9, 1), 1'b1, s);
    check("br_lu_stall", 32'(hif.stall), 0);
    check("br_lu_fii", 32'(hif.flush_if_id), 1);
    check("br_lu_fie", 32'(hif.flush_id_ex), 1);
    step(nop(), 1'b0, s);
    check("br_lu_bubble_fa", 32'(hif.forward_a), 0);
    check("br_lu_sc", hif.stall_count, 1);
    check("br_lu_fc", hif.flush_count, 1);

    // Saturation of the 4-bit instance.
    for (int k = 0; k < 20; k++) begin
      step(ld(9, 1), 1'b0, s);
      step(alu(10, 9, 1), 1'b0, s);
      step(alu(10, 9, 1), 1'b0, s);
    end
    step(nop(), 1'b0, s);
    check("sat_sc4", 32'(hif4.stall_count), 15);
    check("sat_sc32", hif.stall_count, 21);

    // Asynchronous reset in the middle of a stall cycle.
    step(ld(9, 1), 1'b0, s);
    @(negedge clk);
    drive(alu(10, 9, 1), 1'b0);
    #1 check("rst_pre_stall", 32'(hif.stall), 1);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    do_reset();

    // First edge after reset loads EX normally.
    step(alu(5, 1, 2), 1'b0, s);
    step(alu(6, 5, 5), 1'b0, s);
    step(nop(), 1'b0, s);
    check("post_rst_fa", 32'(hif.forward_a), 32'(2'b10));

    // Random traffic; a stalled ID instruction is re-presented.
    cur = rnd_ins();
    for (int k = 0; k < 600; k++) begin
      step(cur, ($urandom_range(0, 7) == 0), s);
      if (!s) cur = rnd_ins();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and operand-forwarding controller for the 5-stage core. It shadows the ID/EX/MEM/WB destination information and drives the ALU's `forward_a`/`forward_b` selects (00 register file, 01 WB result, 10 MEM result). It also generates the load-use stall and the taken-branch flush for the IF/ID and ID/EX pipeline registers. It sits beside the ID/EX/MEM/WB registers and keeps 32-bit saturating stall and flush event counters for performance debug.

## Interface
- `CNT_W`, 32, width of the stall/flush event counters.
- `clk` in 1: core clock. Sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs1`, `id_rs2` in 5: ID-stage source register indices.
- `id_uses_rs1`, `id_uses_rs2` in 1: the instruction actually reads that source.
- `id_rd` in 5: ID-stage destination index.
- `id_reg_write` in 1: ID instruction writes `id_rd`.
- `id_mem_read` in 1: ID instruction is a load.
- `branch_taken` in 1: the EX-stage instruction resolved as taken this cycle.
- `forward_a`, `forward_b` out 2: ALU operand selects for the EX-stage instruction.
- `stall` out 1: hold the PC and IF/ID register this cycle.
- `flush_if_id` out 1: clear IF/ID this cycle.
- `flush_id_ex` out 1: load a bubble into ID/EX this cycle.
- `stall_count`, `flush_count` out CNT_W: saturating event counters.

## Operation
- Internal stage records:
  - EX: valid, rs1, rs2, uses_rs1, uses_rs2, rd, reg_write, mem_read.
  - MEM: valid, rd, reg_write.
  - WB: valid, rd, reg_write.
- Every edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields, or a bubble (valid=0, all fields 0) when `stall` or `flush_id_ex` is 1 or `id_valid` is 0.
- A stage is a forwarding source (`src(S)`) when S.valid & S.reg_write & (S.rd != 0).
- `forward_a`:
  - 10 if EX.uses_rs1 & src(MEM) & MEM.rd==EX.rs1.
  - Else 01 if EX.uses_rs1 & src(WB) & WB.rd==EX.rs1.
  - Else 00.
  - MEM has priority over WB.
  - Forced 00 when EX.valid=0.
- `forward_b`: same rule using rs2 and uses_rs2.
- Load-use stall:
  - `lu` = id_valid & EX.valid & EX.mem_read & EX.rd!=0 & ((id_uses_rs1 & EX.rd==id_rs1) | (id_uses_rs2 & EX.rd==id_rs2)).
- Flush: `flush_if_id` = `flush_id_ex` = `branch_taken`.
- Load-use stall drives `flush_id_ex`: `flush_id_ex` = branch_taken | lu.
- `stall` = lu & ~branch_taken. Flush overrides stall because the stalled ID instruction is on the wrong path.
- Counters:
  - `stall_count` increments on each cycle with `stall`=1.
  - `flush_count` increments on each cycle with `branch_taken`=1.
  - Both saturate at all-ones and never wrap.
- A WB-stage write colliding with an ID-stage read of the same register is resolved by the register file's write-first bypass, not by this block.

## Timing
- `forward_a`/`forward_b`, `stall` and flushes are combinational from registered state and the current ID/branch inputs. Zero-cycle latency; valid within the same cycle.
- Load-use penalty is exactly 1 cycle:
  - Cycle n: load in EX, consumer in ID, `stall`=1.
  - Cycle n+1: bubble in EX, no stall.
  - Cycle n+2: consumer in EX with the load in WB, forward=01.
- Back-to-back ALU dependency: 0 stall, forward=10. Gap of one instruction: forward=01. Gap of two: 00.
- `branch_taken` and `lu` in the same cycle: `stall`=0, both flushes=1, and `stall_count` is not incremented.
- Reset, asynchronous and at any point (including mid-stall):
  - All stage records invalid.
  - Forward selects 00; stall/flush outputs 0.
  - Counters 0.
  - First post-reset edge loads EX from ID normally.
- rd=x0 is never a forwarding or stall source.

## Test plan
- ALU chain: `add x5,x1,x2` then `sub x6,x5,x3` -> in the sub's EX cycle `forward_a`=10, `forward_b`=00, `stall` never asserted.
- One-gap dependency: `add x5`, `nop`, `and x7,x3,x5` -> `forward_b`=01 in the and's EX cycle. With a two-instruction gap -> `forward_b`=00.
- Double hazard: `add x5`, `or x5`, `add x8,x5,x5` -> both selects 10 (MEM priority over WB).
- Load-use: `ld x9` then `add x10,x9,x1`:
  - `stall`=1 and `flush_id_ex`=1 for exactly one cycle; `stall_count` 0->1.
  - Two cycles later `forward_a`=01.
  - Same sequence targeting x0 -> no stall, forwards 00.
- Branch plus load-use collision: `branch_taken`=1 in the same cycle as a load-use match -> `stall`=0, `flush_if_id`=`flush_id_ex`=1, `flush_count`+1, `stall_count` unchanged; the next EX is a bubble.
- Reset and saturation:
  - Assert `rst` during a stall cycle -> all outputs 0 immediately, without waiting for a clock edge.
  - With `CNT_W`=4, 20 consecutive stalls -> `stall_count` holds at 15.
